// File: rtl/rs_decode_sequencer.sv
// rs_decode_sequencer: top-level controller for the RS(204,188) t=8 decoder.
// Moves one codeword at a time through syndrome, key-equation solver, Chien search,
// error magnitude and correction. Each stage's start is gated and results are
// cross-checked between stages. Uncorrectable codewords are flagged and
// per-stream statistics are kept.
module rs_decode_sequencer #(
    parameter int unsigned FORNEY_LAT = 12,
    parameter int unsigned TIMEOUT    = 512,
    parameter int unsigned T_MAX      = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        cw_valid,
    output logic        cw_ready,
    output logic        synd_start,
    input  logic        synd_done,
    input  logic        synd_zero,
    output logic        kes_start,
    input  logic        kes_done,
    input  logic [3:0]  kes_deg,
    output logic        chien_start,
    input  logic        chien_done,
    input  logic [3:0]  chien_roots,
    output logic        em_start,
    output logic        em_load,
    output logic        corr_start,
    output logic        corr_bypass,
    input  logic        corr_done,
    output logic        cw_done,
    output logic [3:0]  err_count,
    output logic        uncorrectable,
    output logic        timeout,
    output logic        busy,
    output logic [15:0] cw_cnt,
    output logic [15:0] fail_cnt
);

    // One counter serves as both the watchdog and the FORNEY latency timer.
    // It is cleared on every state change, so the two uses never overlap.
    localparam int unsigned CW = $clog2(TIMEOUT + FORNEY_LAT);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FL_LAST = CW'(FORNEY_LAT - 1);
    localparam logic [3:0]    TMAX4   = 4'(T_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_SYND, S_KES, S_CHIEN, S_FORNEY, S_FAIL, S_CORR, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_en, wd_exp;
    logic [3:0]    deg_r;
    logic [3:0]    pend_err;
    logic          fail_r, tout_r, byp_r;

    logic          accept, ld_deg, set_tout, set_pend, set_byp, byp_val;
    logic [3:0]    pend_val;
    logic          finish, fin_to, fin_fail;

    assign cnt_en = (state == S_SYND) || (state == S_KES) || (state == S_CHIEN) ||
                    (state == S_CORR) || (state == S_FORNEY);
    assign wd_exp = (cnt == WD_LAST);

    assign cw_ready    = accept;
    assign synd_start  = (state == S_SYND);
    assign kes_start   = (state == S_KES);
    assign chien_start = (state == S_CHIEN);
    assign em_start    = (state == S_FORNEY);
    assign em_load     = (state == S_FORNEY) && (cnt == FL_LAST);
    assign corr_start  = (state == S_CORR);
    assign corr_bypass = (state == S_CORR) && byp_r;
    assign cw_done     = (state == S_DONE);
    assign busy        = (state != S_IDLE);

    // Next-state decode and per-cycle update strobes; a done input beats the watchdog.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ld_deg    = 1'b0;
        set_tout  = 1'b0;
        set_pend  = 1'b0;
        pend_val  = '0;
        set_byp   = 1'b0;
        byp_val   = 1'b0;
        finish    = 1'b0;
        fin_to    = 1'b0;
        fin_fail  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cw_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_SYND;
                end
            end
            S_SYND: begin
                if (synd_done) begin
                    if (synd_zero) begin
                        set_pend  = 1'b1;
                        set_byp   = 1'b1;
                        byp_val   = 1'b1;
                        state_nxt = S_CORR;
                    end else begin
                        state_nxt = S_KES;
                    end
                end else if (wd_exp) begin
                    set_tout  = 1'b1;
                    state_nxt = S_FAIL;
                end
            end
            S_KES: begin
                if (kes_done) begin
                    if ((kes_deg == '0) || (kes_deg > TMAX4)) begin
                        state_nxt = S_FAIL;
                    end else begin
                        ld_deg    = 1'b1;
                        state_nxt = S_CHIEN;
                    end
                end else if (wd_exp) begin
                    set_tout  = 1'b1;
                    state_nxt = S_FAIL;
                end
            end
            S_CHIEN: begin
                if (chien_done) begin
                    state_nxt = (chien_roots != deg_r) ? S_FAIL : S_FORNEY;
                end else if (wd_exp) begin
                    set_tout  = 1'b1;
                    state_nxt = S_FAIL;
                end
            end
            S_FORNEY: begin
                if (cnt == FL_LAST) begin
                    set_pend  = 1'b1;
                    pend_val  = deg_r;
                    set_byp   = 1'b1;
                    byp_val   = 1'b0;
                    state_nxt = S_CORR;
                end
            end
            S_FAIL: begin
                set_byp   = 1'b1;
                byp_val   = 1'b1;
                state_nxt = S_CORR;
            end
            S_CORR: begin
                if (corr_done) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end else if (wd_exp) begin
                    finish    = 1'b1;
                    fin_to    = 1'b1;
                    state_nxt = S_DONE;
                end
                fin_fail = fail_r | fin_to;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, counter, per-codeword context and result/statistics registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            deg_r         <= '0;
            pend_err      <= '0;
            fail_r        <= 1'b0;
            tout_r        <= 1'b0;
            byp_r         <= 1'b0;
            err_count     <= '0;
            uncorrectable <= 1'b0;
            timeout       <= 1'b0;
            cw_cnt        <= '0;
            fail_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt_en) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                fail_r   <= 1'b0;
                tout_r   <= 1'b0;
                pend_err <= '0;
            end
            if (state == S_FAIL) fail_r <= 1'b1;
            if (set_tout) tout_r <= 1'b1;
            if (ld_deg) deg_r <= kes_deg;
            if (set_pend) pend_err <= pend_val;
            if (set_byp) byp_r <= byp_val;
            if (finish) begin
                uncorrectable <= fin_fail;
                timeout       <= tout_r | fin_to;
                err_count     <= fin_fail ? 4'd0 : pend_err;
                cw_cnt        <= cw_cnt + 16'd1;
                if (fin_fail && (fail_cnt != 16'hFFFF)) fail_cnt <= fail_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// tb_rs_decode_sequencer: table-driven bench with reactive stage responders and a
// scoreboard of per-codeword results checked when cw_done appears.
module tb_rs_decode_sequencer;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        cw_valid = 1'b0;
    logic        cw_ready;
    logic        synd_start;
    logic        synd_done = 1'b0;
    logic        synd_zero = 1'b0;
    logic        kes_start;
    logic        kes_done = 1'b0;
    logic [3:0]  kes_deg = '0;
    logic        chien_start;
    logic        chien_done = 1'b0;
    logic [3:0]  chien_roots = '0;
    logic        em_start;
    logic        em_load;
    logic        corr_start;
    logic        corr_bypass;
    logic        corr_done = 1'b0;
    logic        cw_done;
    logic [3:0]  err_count;
    logic        uncorrectable;
    logic        timeout;
    logic        busy;
    logic [15:0] cw_cnt;
    logic [15:0] fail_cnt;

    always #5 Clk = ~Clk;

    rs_decode_sequencer #(.FORNEY_LAT(12), .TIMEOUT(512), .T_MAX(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .cw_valid(cw_valid), .cw_ready(cw_ready),
        .synd_start(synd_start), .synd_done(synd_done), .synd_zero(synd_zero),
        .kes_start(kes_start), .kes_done(kes_done), .kes_deg(kes_deg),
        .chien_start(chien_start), .chien_done(chien_done), .chien_roots(chien_roots),
        .em_start(em_start), .em_load(em_load), .corr_start(corr_start),
        .corr_bypass(corr_bypass), .corr_done(corr_done), .cw_done(cw_done),
        .err_count(err_count), .uncorrectable(uncorrectable), .timeout(timeout),
        .busy(busy), .cw_cnt(cw_cnt), .fail_cnt(fail_cnt)
    );

    // Latencies of 0 mean the stage never answers.
    typedef struct {
        bit sz; int deg; int roots; int sl; int kl; int cl; int rl;
        int e_err; bit e_unc; bit e_to; bit e_byp;
        int e_synd; int e_kes; int e_chien; int e_em; int e_corr;
    } vec_t;

    typedef struct { int err; int unc; int to; int cw; int fl; } exp_t;

    int          nchk = 0;
    int          nfail = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] exp_cw = '0;
    logic [15:0] exp_fail = '0;
    vec_t        vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " ctrl"}, int'({cw_ready, synd_start, kes_start, chien_start, em_start,
            em_load, corr_start, corr_bypass, cw_done, uncorrectable, timeout, busy}), 0);
        chk({tag, " err_count"}, int'(err_count), 0);
        chk({tag, " cw_cnt"}, int'(cw_cnt), 0);
        chk({tag, " fail_cnt"}, int'(fail_cnt), 0);
    endtask

    // Scoreboard consumer: every cw_done must match the oldest outstanding codeword.
    always @(negedge Clk) begin
        if (Rst_n && cw_done) begin
            if (sb.size() == 0) begin
                chk("spurious cw_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb err_count", int'(err_count), mon_e.err);
                chk("sb uncorrectable", int'(uncorrectable), mon_e.unc);
                chk("sb timeout", int'(timeout), mon_e.to);
                chk("sb cw_cnt", int'(cw_cnt), mon_e.cw);
                chk("sb fail_cnt", int'(fail_cnt), mon_e.fl);
            end
        end
    end

    task automatic run_cw(input vec_t v, input int idx, input bit hold, input int stop_em,
                          output bit aborted);
        int   cs, ck, cc, cf, cr, nload, loadpos, extra;
        bit   byp, byp_bad, acc, got;
        exp_t e;
        cs = 0; ck = 0; cc = 0; cf = 0; cr = 0; nload = 0; loadpos = 0; extra = 0;
        byp = 1'b0; byp_bad = 1'b0; acc = 1'b0; got = 1'b0; aborted = 1'b0;
        cw_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            #1;
            if (cw_ready) acc = 1'b1;
            else @(negedge Clk);
        end
        if (!acc) begin
            chk($sformatf("v%0d accept", idx), 0, 1);
            cw_valid = 1'b0;
            return;
        end
        exp_cw = exp_cw + 16'd1;
        if (v.e_unc && exp_fail != 16'hFFFF) exp_fail = exp_fail + 16'd1;
        e.err = v.e_err; e.unc = int'(v.e_unc); e.to = int'(v.e_to);
        e.cw = int'(exp_cw); e.fl = int'(exp_fail);
        sb.push_back(e);
        @(negedge Clk);
        if (!hold) cw_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && !got && !aborted; cyc++) begin
            synd_done = 1'b0; synd_zero = 1'b0; kes_done = 1'b0;
            chien_done = 1'b0; corr_done = 1'b0;
            if (cw_done) begin
                got = 1'b1;
            end else begin
                if (cw_ready) extra++;
                if (synd_start) begin
                    cs++;
                    if (cs == v.sl) begin synd_done = 1'b1; synd_zero = v.sz; end
                end
                if (kes_start) begin
                    ck++;
                    if (ck == v.kl) begin kes_done = 1'b1; kes_deg = 4'(v.deg); end
                end
                if (chien_start) begin
                    cc++;
                    if (cc == v.cl) begin chien_done = 1'b1; chien_roots = 4'(v.roots); end
                end
                if (em_start) begin
                    cf++;
                    if (em_load) begin nload++; loadpos = cf; end
                    if (stop_em != 0 && cf == stop_em) aborted = 1'b1;
                end
                if (corr_start) begin
                    cr++;
                    if (cr == 1) byp = corr_bypass;
                    else if (corr_bypass != byp) byp_bad = 1'b1;
                    if (cr == v.rl) corr_done = 1'b1;
                end
                if (!aborted) @(negedge Clk);
            end
        end
        if (aborted) return;
        if (!got) begin
            chk($sformatf("v%0d cw_done within budget", idx), 0, 1);
            return;
        end
        chk($sformatf("v%0d synd cycles", idx), cs, v.e_synd);
        chk($sformatf("v%0d kes cycles", idx), ck, v.e_kes);
        chk($sformatf("v%0d chien cycles", idx), cc, v.e_chien);
        chk($sformatf("v%0d em_start cycles", idx), cf, v.e_em);
        chk($sformatf("v%0d em_load pulses", idx), nload, (v.e_em != 0) ? 1 : 0);
        if (v.e_em != 0) chk($sformatf("v%0d em_load position", idx), loadpos, v.e_em);
        chk($sformatf("v%0d corr cycles", idx), cr, v.e_corr);
        chk($sformatf("v%0d corr_bypass", idx), int'(byp), int'(v.e_byp));
        chk($sformatf("v%0d corr_bypass stable", idx), int'(byp_bad), 0);
        chk($sformatf("v%0d cw_ready while busy", idx), extra, 0);
        @(negedge Clk);
        chk($sformatf("v%0d cw_done width", idx), int'(cw_done), 0);
        chk($sformatf("v%0d idle after done", idx), int'(busy), 0);
        if (hold) begin
            #1;
            chk($sformatf("v%0d accept on first idle", idx), int'(cw_ready), 1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global time limit: actual running required finished");
        $fatal(1, "time limit");
    end

    initial begin
        bit   ab;
        int   seen;
        vec_t rf;
        //            sz deg rt  sl   kl   cl   rl  | err unc to byp synd kes chien em corr
        vecs[0]  = '{1, 0, 0, 204, 0,   0,   204,  0, 0, 0, 1, 204, 0,   0,   0,  204};
        vecs[1]  = '{0, 8, 8, 5,   7,   9,   6,    8, 0, 0, 0, 5,   7,   9,   12, 6};
        vecs[2]  = '{0, 5, 4, 4,   6,   8,   5,    0, 1, 0, 1, 4,   6,   8,   0,  5};
        vecs[3]  = '{0, 9, 9, 3,   4,   5,   3,    0, 1, 0, 1, 3,   4,   0,   0,  3};
        vecs[4]  = '{0, 0, 0, 3,   4,   5,   3,    0, 1, 0, 1, 3,   4,   0,   0,  3};
        vecs[5]  = '{0, 6, 6, 2,   3,   0,   4,    0, 1, 1, 1, 2,   3,   512, 0,  4};
        vecs[6]  = '{0, 3, 3, 2,   3,   512, 4,    3, 0, 0, 0, 2,   3,   512, 12, 4};
        vecs[7]  = '{1, 0, 0, 6,   0,   0,   0,    0, 1, 1, 1, 6,   0,   0,   0,  512};
        vecs[8]  = '{0, 1, 1, 1,   1,   1,   1,    1, 0, 0, 0, 1,   1,   1,   12, 1};
        vecs[9]  = '{0, 0, 0, 0,   0,   0,   3,    0, 1, 1, 1, 512, 0,   0,   0,  3};
        vecs[10] = '{0, 2, 2, 2,   512, 3,   2,    2, 0, 0, 0, 2,   512, 3,   12, 2};
        rf       = '{0, 4, 4, 2,   2,   2,   2,    4, 0, 0, 0, 2,   2,   2,   12, 2};

        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        check_zero("reset");

        for (int i = 0; i < 11; i++) run_cw(vecs[i], i, 1'b0, 0, ab);

        // cw_valid held high across a codeword: ignored while busy, taken on first IDLE.
        run_cw(vecs[8], 11, 1'b1, 0, ab);
        run_cw(vecs[1], 12, 1'b0, 0, ab);

        // Reset in the middle of FORNEY abandons the codeword silently.
        run_cw(rf, 13, 1'b0, 5, ab);
        chk("reached mid-FORNEY", int'(ab), 1);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        sb.delete();
        exp_cw = '0;
        exp_fail = '0;
        check_zero("mid-FORNEY reset");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (cw_done || busy || em_start) seen++;
        end
        chk("quiet after reset", seen, 0);
        run_cw(vecs[1], 14, 1'b0, 0, ab);

        chk("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
